// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: two requesters share one registered 16-bit logical barrel shifter, round-robin.
// Define BSA_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).

module barrel_shift_arbiter
`ifdef BSA_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic        req0_dir,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    input  logic        req1_dir,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic        busy
`ifdef BSA_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload while valid is high and ready is low.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        can_accept;
    logic        accept;
    logic [15:0] op_data;
    logic [3:0]  op_amt;
    logic        op_dir;
    logic        op_id;
    logic [15:0] st1;
    logic [15:0] st2;
    logic [15:0] st3;
    logic [15:0] shift_out;

    // rst_n gates the readies so they drop immediately when reset is asserted.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        can_accept = rst_n & ((state == IDLE) | ((state == DONE) & res_ready));
        req0_ready = can_accept & grant0;
        req1_ready = can_accept & grant1;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   next_state = DONE;
            DONE: begin
                if (accept)         next_state = SHIFT;
                else if (res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Four binary stages s0..s3 (1, 2, 4, 8 bits); dir=1 shifts left, zero fill either way.
    always_comb begin
        st1 = op_data;
        if (op_amt[0]) st1 = op_dir ? {op_data[14:0], 1'b0} : {1'b0, op_data[15:1]};
        st2 = st1;
        if (op_amt[1]) st2 = op_dir ? {st1[13:0], 2'b0} : {2'b0, st1[15:2]};
        st3 = st2;
        if (op_amt[2]) st3 = op_dir ? {st2[11:0], 4'b0} : {4'b0, st2[15:4]};
        shift_out = st3;
        if (op_amt[3]) shift_out = op_dir ? {st3[7:0], 8'b0} : {8'b0, st3[15:8]};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_data    <= '0;
            op_amt     <= '0;
            op_dir     <= 1'b0;
            op_id      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_data    <= grant1 ? req1_data : req0_data;
                op_amt     <= grant1 ? req1_amt  : req0_amt;
                op_dir     <= grant1 ? req1_dir  : req0_dir;
                op_id      <= grant1;
                last_grant <= grant1;
            end
            if (state == SHIFT) begin
                res_valid <= 1'b1;
                res_data  <= shift_out;
                res_id    <= op_id;
            end else if ((state == DONE) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef BSA_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept && !grant1 && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (accept &&  grant1 && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter against a transaction-level reference model.
// Define BSA_STATS_EN to also exercise the grant counters (including a CNT_W=2 instance).

module tb_barrel_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_dir;
    logic [15:0] req0_data;
    logic [3:0]  req0_amt;
    logic        req1_valid, req1_ready, req1_dir;
    logic [15:0] req1_data;
    logic [3:0]  req1_amt;
    logic        res_valid, res_ready, res_id, busy;
    logic [15:0] res_data;
`ifdef BSA_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [1:0]  sat_cnt0, sat_cnt1;
    logic        s_r0, s_r1, s_rv, s_rid, s_busy;
    logic [15:0] s_rd;
`endif

    barrel_shift_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
`ifdef BSA_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

`ifdef BSA_STATS_EN
    barrel_shift_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_r0), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(s_r1), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .res_valid(s_rv), .res_ready(res_ready), .res_data(s_rd),
        .res_id(s_rid), .busy(s_busy),
        .grant_cnt0(sat_cnt0), .grant_cnt1(sat_cnt1)
    );
`endif

    always #5 clk = ~clk;

    // Reference model: queue of in-flight results {id, data}, a flag for "accepted at the
    // previous edge" (result not yet visible), the last granted requester and accept counts.
    logic [16:0] exp_q[$];
    bit          m_shift;
    bit          m_last;
    bit          m_r0, m_r1;
    int          m_cnt0, m_cnt1;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] amt, input logic dir);
        logic [15:0] r;
        r = dir ? (d << amt) : (d >> amt);
        return r;
    endfunction

    function automatic bit exp_res_valid();
        return (exp_q.size() != 0) && !m_shift;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_shift = 0; m_last = 1; m_r0 = 0; m_r1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // Drive one cycle's inputs (at edge+1), let them settle and predict the readies.
    task automatic drive(input logic v0, input logic [15:0] d0, input logic [3:0] a0, input logic dr0,
                         input logic v1, input logic [15:0] d1, input logic [3:0] a1, input logic dr1,
                         input logic rr);
        bit can, g0, g1;
        req0_valid = v0; req0_data = d0; req0_amt = a0; req0_dir = dr0;
        req1_valid = v1; req1_data = d1; req1_amt = a1; req1_dir = dr1;
        res_ready  = rr;
        #1;
        can  = (exp_q.size() == 0) || (!m_shift && rr);
        g0   = v0 && (!v1 || m_last);
        g1   = v1 && (!v0 || !m_last);
        m_r0 = can && g0;
        m_r1 = can && g1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    endtask

    // Account for the transfers predicted for this cycle, then move to the next edge+1.
    task automatic advance();
        bit acc;
        acc = 0;
        if (exp_res_valid() && res_ready) void'(exp_q.pop_front());
        if (m_r0 && req0_valid) begin
            exp_q.push_back({1'b0, ref_shift(req0_data, req0_amt, req0_dir)});
            m_last = 0; m_cnt0++; acc = 1;
        end else if (m_r1 && req1_valid) begin
            exp_q.push_back({1'b1, ref_shift(req1_data, req1_amt, req1_dir)});
            m_last = 1; m_cnt1++; acc = 1;
        end
        m_shift = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            advance();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        req0_data = 16'h0; req0_amt = 0; req0_dir = 0;
        req1_data = 16'h0; req1_amt = 0; req1_dir = 0;
        #1;
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (res_data !== 16'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0000", res_data); end
        n_checks++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id: got %b want 0", res_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        apply_reset();
    endtask

    logic        dv_id  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dv_data[7] = '{16'ha861, 16'hffff, 16'h8000, 16'h8000, 16'h0001, 16'h1234, 16'hbeef};
    logic [3:0]  dv_amt [7] = '{4'd6, 4'd1, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
    logic        dv_dir [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] dv_exp [7] = '{16'h1840, 16'h7fff, 16'h0000, 16'h0001, 16'h8000, 16'h1234, 16'hbeef};

    task automatic test_shift_directed();
        for (int i = 0; i < 7; i++) begin
            if (dv_id[i] == 1'b0) drive(1'b1, dv_data[i], dv_amt[i], dv_dir[i], 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
            else                  drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, dv_data[i], dv_amt[i], dv_dir[i], 1'b1);
            n_checks++;
            if ({req1_ready, req0_ready} !== (dv_id[i] ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL dir_ready[%0d]: got %b%b want id %0d only", i, req1_ready, req0_ready, dv_id[i]);
            end
            advance();
            n_checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL dir_shift_state[%0d]: got valid=%b busy=%b want 0 1", i, res_valid, busy);
            end
            drive_idle();
            advance();
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid[%0d]: got %b want 1", i, res_valid); end
            n_checks++; if (res_data !== dv_exp[i] || res_id !== dv_id[i]) begin
                n_fail++; $display("FAIL dir_result[%0d]: got id=%b data=%h want id=%b data=%h", i, res_id, res_data, dv_id[i], dv_exp[i]);
            end
            drive_idle();
            advance();
            n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL dir_release[%0d]: got valid=%b busy=%b want 0 0", i, res_valid, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        int n_acc;
        bit want_id;
        apply_reset();
        n_acc = 0;
        want_id = 0;
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (res_valid !== exp_res_valid()) begin n_fail++; $display("FAIL rr_res_valid[%0d]: got %b want %b", c, res_valid, exp_res_valid()); end
            if (exp_res_valid()) begin
                n_checks++;
                if ({res_id, res_data} !== exp_q[0]) begin n_fail++; $display("FAIL rr_result[%0d]: got %h want %h", c, {res_id, res_data}, exp_q[0]); end
            end
            drive(1'b1, 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'b1, 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
            n_checks++;
            if (req0_ready !== m_r0 || req1_ready !== m_r1 || (req0_ready & req1_ready)) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b%b want %b%b", c, req1_ready, req0_ready, m_r1, m_r0);
            end
            if (m_r0 || m_r1) begin
                n_checks++;
                if (req1_ready !== want_id || (req0_ready | req1_ready) !== 1'b1) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got r1=%b r0=%b want grant %0d", c, req1_ready, req0_ready, want_id);
                end
                want_id = !want_id;
                n_acc++;
            end
            advance();
        end
        n_checks++;
        if (n_acc !== 6) begin n_fail++; $display("FAIL rr_throughput: got %0d accepts want 6", n_acc); end
        drain();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h5a3c, 4'd3, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        advance();
        drive_idle();
        advance();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 16'($urandom()), 4'd1, 1'b1, 1'b1, 16'($urandom()), 4'd2, 1'b0, 1'b0);
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b%b want 00", c, req1_ready, req0_ready);
            end
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h0b47 || res_id !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%b data=%h want 1 0 0b47", c, res_valid, res_id, res_data);
            end
            advance();
        end
        drive(1'b1, 16'h00f0, 4'd4, 1'b1, 1'b1, 16'h0f00, 4'd4, 1'b0, 1'b1);
        n_checks++;
        if ((req0_ready | req1_ready) !== 1'b1 || req0_ready !== m_r0 || req1_ready !== m_r1) begin
            n_fail++; $display("FAIL bp_release_accept: got %b%b want %b%b", req1_ready, req0_ready, m_r1, m_r0);
        end
        advance();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_after_release: got valid=%b busy=%b want 0 1", res_valid, busy);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'h1111, 4'd1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        advance();
        req0_valid = 1; req1_valid = 1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got v=%b busy=%b r=%b%b want all 0", res_valid, busy, req1_ready, req0_ready);
        end
        req0_valid = 0; req1_valid = 0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_result[%0d]: got %b want 0", c, res_valid); end
            drive_idle();
            advance();
        end
        drive(1'b1, 16'h0003, 4'd2, 1'b1, 1'b1, 16'h0004, 4'd2, 1'b0, 1'b1);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_first_grant: got %b%b want 01", req1_ready, req0_ready);
        end
        advance();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (res_valid !== exp_res_valid() || busy !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_status[%0d]: got v=%b busy=%b want %b %b", c, res_valid, busy, exp_res_valid(), exp_q.size() != 0);
            end
            if (exp_res_valid()) begin
                n_checks++;
                if ({res_id, res_data} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", c, {res_id, res_data}, exp_q[0]); end
            end
            drive(1'($urandom_range(0, 1)), 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (req0_ready !== m_r0 || req1_ready !== m_r1) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, req1_ready, req0_ready, m_r1, m_r0);
            end
            advance();
        end
        drain();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_drained: got v=%b busy=%b want 0 0", res_valid, busy); end
    endtask

`ifdef BSA_STATS_EN
    task automatic test_stats();
        int e0, e1;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, 16'($urandom()), 4'd1, 1'b0, 1'b1, 16'($urandom()), 4'd1, 1'b1, 1'b1);
            advance();
        end
        drain();
        n_checks++;
        if (grant_cnt0 !== 16'(m_cnt0) || grant_cnt1 !== 16'(m_cnt1) || m_cnt0 != 3 || m_cnt1 != 2) begin
            n_fail++; $display("FAIL stats_counts: got %0d %0d want 3 2 (model %0d %0d)", grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 16'h1, 4'd0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
            advance();
            drain();
        end
        e0 = (m_cnt0 > 3) ? 3 : m_cnt0;
        e1 = (m_cnt1 > 3) ? 3 : m_cnt1;
        n_checks++;
        if (grant_cnt0 !== 16'(m_cnt0) || sat_cnt0 !== 2'(e0) || sat_cnt1 !== 2'(e1)) begin
            n_fail++; $display("FAIL stats_saturate: got %0d sat=%0d/%0d want %0d sat=%0d/%0d", grant_cnt0, sat_cnt0, sat_cnt1, m_cnt0, e0, e1);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_shift_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef BSA_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
